instr_issue_sequencer: RTL and testbench
========================================

INSTR_ISSUE_SEQUENCER -- requirements
Module: instr_issue_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: instruction FIFO depth, a power of two from 2 to 16.
REQ-002 SHALL have parameter SHORT_CYCLES, default 7: hold cycles for a short-opcode instruction, range 1 to 15.
REQ-003 SHALL have parameter LONG_CYCLES, default 9: hold cycles for any other opcode, range 1 to 15.
REQ-004 SHALL have parameter SHORT_OPCODE, default 4'd1: value of instr[3:0] that selects SHORT_CYCLES.
REQ-005 SHALL have parameter IDLE_INSTR, default 14'd0: word driven on instruction while idle.
REQ-006 SHALL have port clock  input  1  single clock, all state updates on its rising edge.
REQ-007 SHALL have port reset_n  input  1  reset; one clock, synchronous and active-low.
REQ-008 SHALL have port in_instr  input  14  instruction word offered by the loader.
REQ-009 SHALL have port in_valid  input  1  in_instr is valid this cycle.
REQ-010 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-011 SHALL have port instruction  output  14  word presented to the CPU core.
REQ-012 SHALL have port issue_start  output  1  one-cycle pulse in the first cycle a new word is on instruction.
REQ-013 SHALL have port busy  output  1  high while a word is being held.
REQ-014 SHALL have port fifo_count  output  5  number of queued words, 0 to DEPTH.

Function
REQ-015 SHALL accept a push on a rising edge only when in_valid and in_ready are both high.
REQ-016 SHALL drive in_ready high when fifo_count < DEPTH, as a function of registered state only.
REQ-017 SHALL ignore in_valid while full; no overwrite occurs and fifo_count stays DEPTH.
REQ-018 SHALL implement states IDLE and HOLD.
REQ-019 IDLE: busy=0; instruction=IDLE_INSTR.
REQ-020 IDLE, at an edge with fifo_count>0: pop the head word, register it onto instruction, set issue_start=1 for the next cycle, set the hold counter, enter HOLD.
REQ-021 Hold counter load value SHALL be (head[3:0]==SHORT_OPCODE ? SHORT_CYCLES : LONG_CYCLES) minus 1.
REQ-022 A word pushed into an empty FIFO SHALL first be visible to the pop logic at the following edge; there is no bypass. It reaches instruction 2 edges after the push edge.
REQ-023 HOLD: busy=1; instruction stable; the counter decrements on each edge while nonzero.
REQ-024 HOLD, at an edge with counter==0 and fifo_count>0: pop the next word back-to-back, pulse issue_start, reload the counter, stay in HOLD.
REQ-025 HOLD, at an edge with counter==0 and fifo_count==0: enter IDLE and drive IDLE_INSTR.
REQ-026 Each issued word SHALL occupy instruction for exactly its hold-cycle count of clock cycles.
REQ-027 On a push and a pop at the same edge, fifo_count SHALL be unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Words SHALL issue in strict FIFO order.

Reset
REQ-030 With reset_n low at an edge: state=IDLE, FIFO emptied, pointers=0, counter=0, instruction=IDLE_INSTR, issue_start=0, busy=0, fifo_count=0, in_ready=1.
REQ-031 Reset mid-HOLD SHALL abort the held word and discard all queued words; none are issued after reset.
REQ-032 Reset SHALL take priority over any push or pop at the same edge.

Configuration
REQ-033 With macro ISSUE_STATS_EN defined: add output issued_count, 16 bits; it resets to 0, increments on each issue_start cycle, and wraps from 16'hFFFF to 0.
REQ-034 Without ISSUE_STATS_EN: the issued_count port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-035 Reset, then push 14'b00000000010001 (opcode 1): instruction shows it 2 edges after the push, busy=1 for exactly 7 cycles, then IDLE_INSTR returns.
REQ-036 Push opcode 2, then opcode 1 back-to-back: held 9 cycles, then 7 cycles; issue_start pulses exactly twice, 9 cycles apart; no IDLE gap between the words.
REQ-037 Push 8 words with the consumer busy: fifo_count=8, in_ready=0; a 9th in_valid is dropped; all 8 words issue in order.
REQ-038 Push 20 words streaming: pointer wrap-around is correct; the issue order matches the push order; fifo_count never exceeds 8.
REQ-039 Assert reset_n=0 for 1 cycle mid-HOLD with 3 words queued: next cycle instruction=IDLE_INSTR, fifo_count=0, and no further issue_start pulses.
REQ-040 With ISSUE_STATS_EN defined, issue 5 words: issued_count=5; a reset returns it to 0.

Source files
------------

// File: rtl/instr_issue_sequencer.sv
// instr_issue_sequencer: FIFO-buffered instruction issuer holding each word for an opcode-dependent cycle count (optional ISSUE_STATS_EN adds issued_count)
module instr_issue_sequencer #(
  parameter int DEPTH = 8,
  parameter int SHORT_CYCLES = 7,
  parameter int LONG_CYCLES = 9,
  parameter logic [3:0] SHORT_OPCODE = 4'd1,
  parameter logic [13:0] IDLE_INSTR = 14'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [13:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [13:0] instruction,
  output logic        issue_start,
  output logic        busy,
`ifdef ISSUE_STATS_EN
  output logic [4:0]  fifo_count,
  output logic [15:0] issued_count
`else
  output logic [4:0]  fifo_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] FULL = 5'(DEPTH);
  localparam logic [3:0] SHORT_LD = 4'(SHORT_CYCLES - 1);
  localparam logic [3:0] LONG_LD = 4'(LONG_CYCLES - 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q;
  logic [13:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [4:0] count_q, count_d;
  logic [3:0] cnt_q;
  logic [13:0] instr_q, head;
  logic start_q, busy_q, push, pop;
  assign head = mem_q[rptr_q];
  assign in_ready = count_q < FULL;
  assign push = in_valid && in_ready;
  assign pop = (count_q != 5'd0) && (state_q == IDLE || cnt_q == 4'd0);
  assign count_d = count_q + 5'(push) - 5'(pop);
  assign instruction = instr_q;
  assign issue_start = start_q;
  assign busy = busy_q;
  assign fifo_count = count_q;
  // Storage needs no reset: occupancy is tracked by count_q and the pointers.
  always_ff @(posedge clock)
    if (push) mem_q[wptr_q] <= in_instr;
  // Issue FSM: pops only from registered occupancy, so a fresh push is seen one edge later.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= 5'd0;
      cnt_q <= 4'd0;
      instr_q <= IDLE_INSTR;
      start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      count_q <= count_d;
      start_q <= pop;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        instr_q <= head;
        cnt_q <= (head[3:0] == SHORT_OPCODE) ? SHORT_LD : LONG_LD;
        state_q <= HOLD;
        busy_q <= 1'b1;
      end else if (state_q == HOLD && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (state_q == HOLD) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
        instr_q <= IDLE_INSTR;
      end
    end
  end
`ifdef ISSUE_STATS_EN
  // Counts issue_start cycles, wrapping naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (!reset_n) issued_count <= 16'd0;
    else if (start_q) issued_count <= issued_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_issue_sequencer.sv
// tb_instr_issue_sequencer: directed scoreboard bench for instr_issue_sequencer
module tb_instr_issue_sequencer;
  logic clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_ready, issue_start, busy;
  logic [13:0] in_instr = 14'd0, instruction;
  logic [4:0] fifo_count;
`ifdef ISSUE_STATS_EN
  logic [15:0] issued_count;
`endif
  int tests = 0, fails = 0, cyc = 0, max_cnt = 0;
  logic [13:0] sb [$];
  int starts [$];

  instr_issue_sequencer dut (
    .clock(clock), .reset_n(reset_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .instruction(instruction), .issue_start(issue_start),
    .busy(busy),
`ifdef ISSUE_STATS_EN
    .issued_count(issued_count),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock)
    if (reset_n) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (issue_start) begin
        starts.push_back(cyc);
        if (sb.size() == 0) chk("unexpected_issue", {31'd0, issue_start}, 32'd0);
        else chk("issue_order", {18'd0, instruction}, {18'd0, sb.pop_front()});
      end
    end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [13:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
    sb.push_back(w);
  endtask

  task automatic busy_run(output int n);
    n = 0;
    for (int i = 0; i < 5 && !busy; i++) tick();
    for (int i = 0; i < 300 && busy; i++) begin
      n++;
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (sb.size() != 0 || busy); i++) tick();
    chk("drain_scoreboard_empty", sb.size(), 32'd0);
    chk("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, n0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst_instruction", {18'd0, instruction}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_issue_start", {31'd0, issue_start}, 32'd0);
    chk("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Short opcode: popped at the edge after the push edge, held 7 cycles.
    push(14'b00000000010001);
    chk("short_count_after_push", {27'd0, fifo_count}, 32'd1);
    chk("short_not_yet_visible", {18'd0, instruction}, 32'd0);
    tick();
    chk("short_visible", {18'd0, instruction}, 32'h11);
    chk("short_issue_start", {31'd0, issue_start}, 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n++;
      tick();
    end
    chk("short_hold_cycles", n, 32'd7);
    chk("short_idle_instr", {18'd0, instruction}, 32'd0);

    // Long then short back-to-back: 9 + 7 cycles with no idle gap.
    n0 = starts.size();
    push(14'h00A2);
    push(14'h0151);
    busy_run(n);
    chk("b2b_busy_run", n, 32'd16);
    chk("b2b_pulse_count", starts.size() - n0, 32'd2);
    if (starts.size() - n0 == 2) chk("b2b_pulse_gap", starts[n0+1] - starts[n0], 32'd9);
    drain();

    // Fill all 8 slots behind a long word, then offer a 9th that must be dropped.
    push(14'h0033);
    tick();
    for (int i = 0; i < 8; i++) push(14'(16 * (i + 5) + (i % 2) + 1));
    chk("full_count", {27'd0, fifo_count}, 32'd8);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_instr = 14'h3FF5;
    tick();
    in_valid = 1'b0;
    chk("full_drop_count", {27'd0, fifo_count}, 32'd7);
    drain();

    // Stream 20 words through the FIFO, exercising pointer wrap.
    max_cnt = 0;
    n0 = starts.size();
    for (int i = 0; i < 20; i++) begin
      for (int g = 0; g < 50 && !in_ready; g++) tick();
      push(14'(37 * i * 16 + (i % 3)));
    end
    drain();
    chk("stream_issue_count", starts.size() - n0, 32'd20);
    chk("stream_max_le_depth", {31'd0, max_cnt <= 8}, 32'd1);

    // Reset mid-hold with three queued words.
    push(14'h0042);
    push(14'h0051);
    push(14'h0062);
    push(14'h0071);
    repeat (2) tick();
    chk("midhold_busy", {31'd0, busy}, 32'd1);
    chk("midhold_count", {27'd0, fifo_count}, 32'd3);
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_instr = 14'h0099;
    tick();
    in_valid = 1'b0;
    reset_n = 1'b1;
    sb.delete();
    chk("rst2_instruction", {18'd0, instruction}, 32'd0);
    chk("rst2_fifo_count", {27'd0, fifo_count}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    n0 = starts.size();
    repeat (30) tick();
    chk("rst2_no_issue", starts.size() - n0, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ISSUE_STATS_EN
    chk("stats_after_reset", {16'd0, issued_count}, 32'd0);
    for (int i = 0; i < 5; i++) push(14'(64 + 16 * i + 1));
    drain();
    chk("stats_five", {16'd0, issued_count}, 32'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("stats_reset", {16'd0, issued_count}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
